// File: rtl/spm_host_pkg.sv
// Shared types and constants for the spm_host sequencer.
//   state_e  : sequencer states (IDLE, CLR, SHIFT, DONE)
//   OP_W     : operand width, PROD_W : product width
//   SER_BITS : product bits streamed per operation
//   cnt_t    : SHIFT-phase cycle counter
package spm_host_pkg;

  localparam int unsigned OP_W     = 8;
  localparam int unsigned PROD_W   = 16;
  localparam int unsigned SER_BITS = 16;
  localparam int unsigned CNT_W    = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/spm_host_if.sv
// Bundle between core logic, spm_host and the serial-parallel multiplier.
//   in_valid/in_ready/a/b        : operand handshake (core -> host)
//   out_valid/out_ready/prod     : result handshake (host -> core)
//   spm_clr/spm_x/spm_y/spm_p    : multiplier side
// slave is the host view; master is the core + multiplier view.
interface spm_host_if;
  import spm_host_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   a;
  logic [OP_W-1:0]   b;
  logic              out_valid;
  logic              out_ready;
  logic [PROD_W-1:0] prod;
  logic              spm_clr;
  logic [OP_W-1:0]   spm_x;
  logic              spm_y;
  logic              spm_p;

  modport slave (
    input  in_valid, a, b, out_ready, spm_p,
    output in_ready, out_valid, prod, spm_clr, spm_x, spm_y
  );

  modport master (
    output in_valid, a, b, out_ready, spm_p,
    input  in_ready, out_valid, prod, spm_clr, spm_x, spm_y
  );

endinterface

// File: rtl/spm_host_deser.sv
// Right-shift sampler for the serial product stream.
//   clk, rst : clock and synchronous active-high reset
//   en       : take one sample this cycle
//   din      : serial product bit (LSB first)
//   next_c   : 16-bit window as it will look after this cycle's sample
module spm_host_deser
  import spm_host_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              din,
  output logic [PROD_W-1:0] next_c
);

  // Bit 0 of the window is only ever shifted out, so 15 flops hold the history.
  logic [PROD_W-2:0] sreg;

  assign next_c = {din, sreg};

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
    end else if (en) begin
      sreg <= next_c[PROD_W-1:1];
    end
  end

endmodule

// File: rtl/spm_host.sv
// Sequencer driving the serial-parallel multiplier from a valid/ready port.
//   clk, rst : clock and synchronous active-high reset
//   bus      : spm_host_if.slave (operand/result handshakes + multiplier pins)
//   LAT      : cycles from driving spm_y bit i to spm_p carrying product bit i
module spm_host
  import spm_host_pkg::*;
#(
  parameter int unsigned LAT = 1
) (
  input logic       clk,
  input logic       rst,
  spm_host_if.slave bus
);

  localparam cnt_t LAST  = cnt_t'(SER_BITS + LAT - 1);
  localparam cnt_t FIRST = cnt_t'(LAT);

  state_e            state_q;
  state_e            state_n;
  logic [OP_W-1:0]   x_q;
  logic [OP_W-1:0]   y_sreg;
  cnt_t              bit_cnt;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              spm_clr_q;
  logic              spm_y_q;
  logic [PROD_W-1:0] prod_q;
  logic [PROD_W-1:0] p_next;
  logic              sample_en;

  // Next state and sample window.
  always_comb begin
    state_n   = state_q;
    sample_en = 1'b0;
    case (state_q)
      IDLE:    if (bus.in_valid) state_n = CLR;
      CLR:     state_n = SHIFT;
      SHIFT: begin
        // The first LAT cycles only prime the multiplier pipeline.
        sample_en = (bit_cnt >= FIRST);
        if (bit_cnt == LAST) state_n = DONE;
      end
      DONE:    if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  spm_host_deser u_deser (
    .clk    (clk),
    .rst    (rst),
    .en     (sample_en),
    .din    (bus.spm_p),
    .next_c (p_next)
  );

  // State, operand registers and registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_sreg      <= '0;
      bit_cnt     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      spm_clr_q   <= 1'b0;
      spm_y_q     <= 1'b0;
      prod_q      <= '0;
    end else begin
      state_q     <= state_n;
      in_ready_q  <= (state_n == IDLE);
      out_valid_q <= (state_n == DONE);
      spm_clr_q   <= (state_n == CLR);
      spm_y_q     <= (state_n == SHIFT) ? y_sreg[0] : 1'b0;
      bit_cnt     <= (state_q == SHIFT) ? bit_cnt + cnt_t'(1) : '0;

      if (state_q == IDLE && bus.in_valid) begin
        x_q    <= bus.a;
        y_sreg <= bus.b;
      end else if (state_n == SHIFT) begin
        // Arithmetic shift: upper serial bits repeat the sign of b.
        y_sreg <= {y_sreg[OP_W-1], y_sreg[OP_W-1:1]};
      end

      // Capture the window together with its final sample.
      if (state_q == SHIFT && state_n == DONE) prod_q <= p_next;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.prod      = prod_q;
  assign bus.spm_clr   = spm_clr_q;
  assign bus.spm_x     = x_q;
  assign bus.spm_y     = spm_y_q;

endmodule

// File: doc/spm_host.md
# spm_host

Sequencer that drives the serial-parallel multiplier (`spm`) from a parallel, valid/ready operand interface and reassembles its serial product into a parallel result.
- Latches an 8-bit multiplicand `a` and an 8-bit multiplier `b`.
- Presents `a` on the parallel port and shifts `b` out LSB-first on the serial port.
- Samples the serial product LSB-first and returns a 16-bit signed product.
- Sits between core logic and the `spm` instance inside the user project wrapper.

## Interface
Parameters:
- `LAT`, default 1: clock cycles between driving `spm_y` bit i and `spm_p` carrying product bit i; legal range 0..3.

Ports:
- `clk`  input  1: single clock; all state on rising edge.
- `rst`  input  1: reset, synchronous, active-high.
- `in_valid`  input  1: operands valid.
- `in_ready`  output  1: block idle, can accept operands.
- `a`  input  8: multiplicand, two's complement, drives `spm_x`.
- `b`  input  8: multiplier, two's complement, serialized to `spm_y`.
- `out_valid`  output  1: `prod` valid.
- `out_ready`  input  1: consumer takes `prod`.
- `prod`  output  16: signed product a*b.
- `spm_clr`  output  1: active-high one-cycle clear pulse to the multiplier.
- `spm_x`  output  8: parallel operand to multiplier.
- `spm_y`  output  1: serial operand to multiplier.
- `spm_p`  input  1: serial product from multiplier.

## Operation
- FSM states: IDLE, CLR, SHIFT, DONE.
  - IDLE: `in_ready`=1. On `in_valid && in_ready`, latch `a` into `x_q`, latch `b` into `y_sreg`, then go to CLR.
  - CLR: one cycle. `spm_clr`=1, `spm_y`=0, `bit_cnt`=0. Next state is SHIFT.
  - SHIFT: for 16+LAT cycles, `spm_y` = `y_sreg[0]`.
    - `y_sreg` shifts arithmetic-right each cycle, so bits 8..15 repeat the sign of `b`.
    - From the LAT-th SHIFT cycle on, each cycle samples `spm_p` into the MSB of `p_sreg` and shifts `p_sreg` right, 16 samples total.
    - After the 16th sample, go to DONE.
  - DONE: `out_valid`=1, `prod`=`p_sreg`. Hold both until `out_ready`=1, then go to IDLE.
- `spm_x` = `x_q` in all states; it is constant for a whole operation.
- Arithmetic: result is the 16-bit two's complement product. No overflow is possible: worst case (-128)*(-128) = 16384.
- `bit_cnt` is 5 bits wide and counts 0..16+LAT-1 in SHIFT.
- Operands presented outside IDLE are ignored, since `in_ready`=0.
- `prod` holds its last value after the handshake until the next DONE.

## Timing
- Edge numbering: E0 = accepting edge, E1, E2, … are the following rising edges.
- Throughput: one operation per 19+LAT cycles with `out_ready` tied high.
- After E0:
  - CLR occupies the cycle between E0 and E1.
  - `spm_y` carries `b` bit i (sign-extended for i ≥ 8) in the cycle after E(1+i), for i = 0..15.
  - `p_sreg` captures product bit i at E(2+i+LAT).
  - `out_valid` is high from E(17+LAT), i.e. 18 cycles after accept for LAT=1.
- `out_valid && out_ready` at edge Ek: `out_valid`=0 and `in_ready`=1 from Ek. Earliest next accept is at Ek+1.
- Reset values: state IDLE, `in_ready`=1 (first cycle after reset), `out_valid`=0, `prod`=0, `spm_clr`=0, `spm_x`=0, `spm_y`=0, `bit_cnt`=0.
- `rst` mid-operation:
  - Aborts immediately; the partial product is discarded and no `out_valid` is produced.
  - The next operation issues its own CLR pulse, so leftover multiplier state is harmless.
- `rst` has priority over every handshake.

## Structure
- Package `spm_host_pkg`:
  - state enum (IDLE, CLR, SHIFT, DONE);
  - constants `OP_W`=8, `PROD_W`=16, `SER_BITS`=16;
  - `cnt_t` (5-bit counter type).
- Natural sub-module: `spm_host_deser`, the 16-bit right-shift sampler with enable. It keeps the sample window logic separate from the FSM.
- The `spm` instance is not inside this block; the wrapper connects the `spm_*` ports to it.

## Test plan
Bench uses the real `spm` instance with LAT=1.
- Basic: `a`=3, `b`=5, `out_ready`=1 → `prod`=0x000F; `out_valid` rises exactly 18 cycles after the accepting edge; exactly one CLR pulse is seen.
- Signs: (-1)×1 → 0xFFFF; 7×(-2) → 0xFFF2; (-128)×(-128) → 0x4000; 127×(-128) → 0xC080.
- Back-pressure: hold `out_ready`=0 for 10 cycles after `out_valid` rises. `prod` and `out_valid` stay stable and `in_ready` stays 0; accept occurs on the cycle `out_ready` goes high.
- Back-to-back: stream 8 random operand pairs with `in_valid` held high. Results arrive in order and match a golden model; the accept-to-accept spacing is 20 cycles.
- Reset mid-op: assert `rst` in SHIFT at `bit_cnt`=7. Next cycle shows `out_valid`=0, `in_ready`=1 and all reset values. A following 9×9 operation yields 0x0051.
- Ignored input: toggle `in_valid` with garbage operands during SHIFT and DONE → result unchanged, no extra accepts.
